demux1to7_deser: RTL and testbench

- Receive-side counterpart to the board's 7-input selector. Takes a single serial bit stream, time-slot by time-slot, and steers each bit into one of 7 parallel output positions, in the same slot-to-bit mapping: slot k feeds out[k].
- Assembles complete 7-bit frames and presents them on a registered parallel bus with a one-cycle valid strobe.
- Sits between a serial source (switch/keys or an upstream serializer) and LED/display logic.

---
 rtl/demux1to7_deser.sv | 89 ++++++++
 tb/tb_demux1to7_deser.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/demux1to7_deser.sv
// demux1to7_deser
// Serial-to-parallel frame assembler. This is the receive-side partner of the
// 7-input selector. Each valid serial bit is steered into the output position
// that matches its time slot, so slot k lands in out[k]. When a frame is
// complete it is published on a registered bus together with a one-cycle
// strobe.
//
// Ports
//   clock      system clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   in         serial data bit for the current slot
//   in_valid   qualifies in; one bit is consumed per cycle while it is high
//   sync       frame-start marker; a qualified bit with sync goes to slot 0
//   out        last completed frame, held until the next frame completes
//   out_valid  one-cycle pulse when out is updated
//   slot       slot index that the next valid bit will be written to
//   frame_err  one-cycle pulse when sync discards a partial frame
//
// State
//   slot          | meaning
//   0             | idle / waiting for the first bit of a frame
//   1..NUM_SLOTS-1| partial frame pending, slot bits already captured
//   >= NUM_SLOTS  | unreachable; the next valid bit returns the counter to 0

module demux1to7_deser #(
    parameter int NUM_SLOTS = 7,
    parameter int SEL_W     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 in_valid,
    input  logic                 sync,
    output logic [NUM_SLOTS-1:0] out,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     slot,
    output logic                 frame_err
);

    localparam logic [SEL_W-1:0] FIRST_SLOT = '0;
    localparam logic [SEL_W-1:0] NEXT_SLOT  = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(NUM_SLOTS - 1);

    // The final bit of a frame goes straight to out. Because of that, the
    // shadow only needs to hold the first NUM_SLOTS-1 bits.
    logic [NUM_SLOTS-2:0] shadow;

    logic slot_in_range;
    assign slot_in_range = (slot <= LAST_SLOT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            slot      <= FIRST_SLOT;
            shadow    <= '0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;

            if (sync) begin
                // Resync. A partial frame is dropped and out is untouched.
                // An aligned sync at slot 0 is silent.
                if (slot != FIRST_SLOT) begin
                    frame_err <= 1'b1;
                end
                if (in_valid) begin
                    shadow[0] <= in;
                    slot      <= NEXT_SLOT;
                end else begin
                    slot <= FIRST_SLOT;
                end
            end else if (in_valid) begin
                if (!slot_in_range) begin
                    slot <= FIRST_SLOT;
                end else if (slot == LAST_SLOT) begin
                    out       <= {in, shadow};
                    out_valid <= 1'b1;
                    slot      <= FIRST_SLOT;
                end else begin
                    shadow[slot] <= in;
                    slot         <= slot + NEXT_SLOT;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1to7_deser.sv
// Directed bench for demux1to7_deser. A table of per-cycle vectors is applied
// in order. Each row is compared against hand-derived expected outputs. The
// table is followed by a hand-written asynchronous-reset sequence.

module tb_demux1to7_deser;

    logic       clock = 1'b0;
    logic       reset;
    logic       in;
    logic       in_valid;
    logic       sync;
    logic [6:0] out;
    logic       out_valid;
    logic [2:0] slot;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       i;
        logic       v;
        logic       s;
        logic [6:0] eo;
        logic       ev;
        logic [2:0] es;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    demux1to7_deser #(.NUM_SLOTS(7), .SEL_W(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .sync      (sync),
        .out       (out),
        .out_valid (out_valid),
        .slot      (slot),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [6:0] eo, input logic ev,
                              input logic [2:0] es, input logic ee);
        chk({tag, " out"}, int'(out), int'(eo));
        chk({tag, " out_valid"}, int'(out_valid), int'(ev));
        chk({tag, " slot"}, int'(slot), int'(es));
        chk({tag, " frame_err"}, int'(frame_err), int'(ee));
        chk({tag, " exclusive"}, int'(out_valid & frame_err), 0);
    endtask

    task automatic step(input string tag, input logic i, input logic v, input logic s,
                        input logic [6:0] eo, input logic ev, input logic [2:0] es,
                        input logic ee);
        in = i; in_valid = v; sync = s;
        @(posedge clock);
        #1;
        check_outs(tag, eo, ev, es, ee);
    endtask

    function automatic void add(input logic i, input logic v, input logic s,
                                input logic [6:0] eo, input logic ev,
                                input logic [2:0] es, input logic ee);
        vec_t r;
        r.i = i; r.v = v; r.s = s; r.eo = eo; r.ev = ev; r.es = es; r.ee = ee;
        vecs.push_back(r);
    endfunction

    // Seven full-rate bits, slot 0 first. The new frame appears on the last row.
    function automatic void add_frame(input logic [6:0] data, input logic sync_first,
                                      input logic [6:0] prev);
        logic [6:0] d;
        d = data;
        for (int k = 0; k < 6; k++)
            add(d[k], 1'b1, (k == 0) ? sync_first : 1'b0, prev, 1'b0, 3'(k + 1), 1'b0);
        add(d[6], 1'b1, 1'b0, data, 1'b1, 3'd0, 1'b0);
    endfunction

    initial begin
        // Frame 1: bits 1,0,1,1,0,0,1 with sync on the first bit -> 7'b1001101.
        add_frame(7'h4D, 1'b1, 7'h00);
        add(1'b0, 1'b0, 1'b0, 7'h4D, 1'b0, 3'd0, 1'b0);
        // Back-to-back 7'h55 then 7'h2A. out then holds.
        add_frame(7'h55, 1'b0, 7'h4D);
        add_frame(7'h2A, 1'b0, 7'h55);
        add(1'b0, 1'b0, 1'b0, 7'h2A, 1'b0, 3'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 7'h2A, 1'b0, 3'd0, 1'b0);
        // 7'h7F with a three-cycle gap after slot 3 is written.
        for (int k = 1; k <= 4; k++) add(1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 3'(k), 1'b0);
        for (int k = 0; k < 3; k++)  add(1'b0, 1'b0, 1'b0, 7'h2A, 1'b0, 3'd4, 1'b0);
        add(1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 3'd5, 1'b0);
        add(1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 3'd6, 1'b0);
        add(1'b1, 1'b1, 1'b0, 7'h7F, 1'b1, 3'd0, 1'b0);
        // Four bits, then sync with a bit -> frame_err, slot 1, out held.
        add(1'b1, 1'b1, 1'b1, 7'h7F, 1'b0, 3'd1, 1'b0);
        for (int k = 2; k <= 4; k++) add(1'b1, 1'b1, 1'b0, 7'h7F, 1'b0, 3'(k), 1'b0);
        add(1'b1, 1'b1, 1'b1, 7'h7F, 1'b0, 3'd1, 1'b1);
        for (int k = 2; k <= 6; k++) add(1'b0, 1'b1, 1'b0, 7'h7F, 1'b0, 3'(k), 1'b0);
        add(1'b0, 1'b1, 1'b0, 7'h01, 1'b1, 3'd0, 1'b0);
        // Sync alone at slot 0 (silent), then at slot 3 (error).
        add(1'b0, 1'b0, 1'b1, 7'h01, 1'b0, 3'd0, 1'b0);
        for (int k = 1; k <= 3; k++) add(1'b1, 1'b1, 1'b0, 7'h01, 1'b0, 3'(k), 1'b0);
        add(1'b0, 1'b0, 1'b1, 7'h01, 1'b0, 3'd0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 7'h01, 1'b0, 3'd0, 1'b0);

        reset = 1'b1; in = 1'b0; in_valid = 1'b0; sync = 1'b0;
        #12;
        check_outs("reset", 7'h00, 1'b0, 3'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[n])
            step($sformatf("row%0d", n), vecs[n].i, vecs[n].v, vecs[n].s,
                 vecs[n].eo, vecs[n].ev, vecs[n].es, vecs[n].ee);

        // Asynchronous reset between edges while five bits are pending.
        for (int k = 1; k <= 5; k++)
            step($sformatf("pre_rst%0d", k), 1'b1, 1'b1, 1'b0, 7'h01, 1'b0, 3'(k), 1'b0);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_outs("async_rst", 7'h00, 1'b0, 3'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        // A fresh frame 7'h33 after reset assembles from slot 0.
        begin
            logic [6:0] d;
            d = 7'h33;
            for (int k = 0; k < 6; k++)
                step($sformatf("post_rst%0d", k), d[k], 1'b1, 1'b0, 7'h00, 1'b0, 3'(k + 1), 1'b0);
            step("post_rst6", d[6], 1'b1, 1'b0, 7'h33, 1'b1, 3'd0, 1'b0);
            step("post_rst_hold", 1'b0, 1'b0, 1'b0, 7'h33, 1'b0, 3'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
